ssid_hit_readout: RTL and testbench

//  Downstream consumer of the SSID hit storage (HNM/HCM/HLM block memories). Accepts one SSID query at a time.

---
 rtl/ssid_hit_readout.sv | 196 +++++++++++++++++++
 tb/tb_ssid_hit_readout.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ssid_hit_readout.sv
// ssid_hit_readout
//   Read-only consumer of the SSID hit storage. Takes one SSID query at a
//   time and does a chained lookup through the three block memories:
//   the HNM hit bit, then the HCM count and HLM address, then the HLM packed row.
//   It then streams the stored hit words, oldest first, over valid/ready.
//   A miss, or a zero count, produces a single noHit beat.
//
// Ports
//   clock, resetN            rising-edge clock, async active-low reset
//   queryValid/queryReady    query handshake; ready only while idle
//   querySSID                SSID to read out
//   hnmAddr/hnmData          HNM read port (1-cycle synchronous read)
//   hcmAddr/hcmData          HCM read port (1-cycle synchronous read)
//   hlmAddr/hlmData          HLM read port (1-cycle synchronous read)
//   hitValid/hitReady        output beat handshake
//   hitInfo                  hit word (0 on a noHit beat)
//   hitLast                  final beat of the query
//   noHit                    beat reports that the SSID had no hits
//   overflow                 stored count exceeded the row capacity
module ssid_hit_readout #(
  parameter int SSIDBITS         = 12,
  parameter int COLINDEXBITS     = 5,
  parameter int HITINFOBITS      = 8,
  parameter int NCOLS_HCM        = 16,
  parameter int ROWINDEXBITS_HLM = 9,
  parameter int MAXHITNBITS      = 4,
  parameter int NCOLS_HLM        = 64
) (
  input  logic                             clock,
  input  logic                             resetN,
  input  logic                             queryValid,
  input  logic [SSIDBITS-1:0]              querySSID,
  output logic                             queryReady,
  output logic [SSIDBITS-COLINDEXBITS-1:0] hnmAddr,
  input  logic [(2**COLINDEXBITS)-1:0]     hnmData,
  output logic [SSIDBITS-1:0]              hcmAddr,
  input  logic [NCOLS_HCM-1:0]             hcmData,
  output logic [ROWINDEXBITS_HLM-1:0]      hlmAddr,
  input  logic [NCOLS_HLM-1:0]             hlmData,
  output logic                             hitValid,
  input  logic                             hitReady,
  output logic [HITINFOBITS-1:0]           hitInfo,
  output logic                             hitLast,
  output logic                             noHit,
  output logic                             overflow
);

  localparam int SLOTS = NCOLS_HLM / HITINFOBITS;
  localparam int KW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [MAXHITNBITS:0] SLOTS_C = SLOTS[MAXHITNBITS:0];

  typedef enum logic [2:0] {
    IDLE, HNM_WAIT, HCM_WAIT, HLM_WAIT, EMIT, NOHIT
  } state_t;

  state_t                                state_q;
  logic                                  phase_q;  // 0: memory capturing address, 1: data valid
  logic [SSIDBITS-1:0]                   ssid_q;
  logic [KW-1:0]                         k_q;      // slot of the beat currently presented
  logic                                  ovf_q;
  logic [SLOTS-1:0][HITINFOBITS-1:0]     row_q;

  // HCM word decode
  logic [MAXHITNBITS-1:0]                cnt_w, cntm1_w;
  logic                                  ovf_w;
  logic [KW-1:0]                         kinit_w, km1_w;
  logic [SLOTS-1:0][HITINFOBITS-1:0]     hlm_slots_w;
  logic                                  hnm_hit_w;

  assign cnt_w       = hcmData[MAXHITNBITS-1:0];
  assign cntm1_w     = cnt_w - 1'b1;
  assign ovf_w       = {1'b0, cnt_w} > SLOTS_C;
  // Beats start at the oldest stored slot; an overflowed row is emitted in full.
  assign kinit_w     = ovf_w ? KW'(SLOTS - 1) : cntm1_w[KW-1:0];
  assign km1_w       = k_q - 1'b1;
  assign hlm_slots_w = hlmData;
  assign hnm_hit_w   = hnmData[ssid_q[COLINDEXBITS-1:0]];

  // HCM bits between the address and count fields carry nothing for us.
  logic unused_hcm;
  assign unused_hcm = ^{hcmData[NCOLS_HCM-ROWINDEXBITS_HLM-1:MAXHITNBITS],
                        cntm1_w[MAXHITNBITS-1:KW]};

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      ssid_q     <= '0;
      k_q        <= '0;
      ovf_q      <= 1'b0;
      row_q      <= '0;
      queryReady <= 1'b1;
      hnmAddr    <= '0;
      hcmAddr    <= '0;
      hlmAddr    <= '0;
      hitValid   <= 1'b0;
      hitInfo    <= '0;
      hitLast    <= 1'b0;
      noHit      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (queryValid) begin
            ssid_q     <= querySSID;
            hnmAddr    <= querySSID[SSIDBITS-1:COLINDEXBITS];
            queryReady <= 1'b0;
            phase_q    <= 1'b0;
            state_q    <= HNM_WAIT;
          end
        end

        HNM_WAIT: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            if (!hnm_hit_w) begin
              hitValid <= 1'b1;
              noHit    <= 1'b1;
              hitLast  <= 1'b1;
              hitInfo  <= '0;
              state_q  <= NOHIT;
            end else begin
              hcmAddr <= ssid_q;
              state_q <= HCM_WAIT;
            end
          end
        end

        HCM_WAIT: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            if (cnt_w == '0) begin
              hitValid <= 1'b1;
              noHit    <= 1'b1;
              hitLast  <= 1'b1;
              hitInfo  <= '0;
              state_q  <= NOHIT;
            end else begin
              hlmAddr <= hcmData[NCOLS_HCM-1 -: ROWINDEXBITS_HLM];
              ovf_q   <= ovf_w;
              k_q     <= kinit_w;
              state_q <= HLM_WAIT;
            end
          end
        end

        HLM_WAIT: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            row_q    <= hlm_slots_w;
            hitInfo  <= hlm_slots_w[k_q];
            hitLast  <= (k_q == '0);
            hitValid <= 1'b1;
            overflow <= ovf_q;
            state_q  <= EMIT;
          end
        end

        EMIT: begin
          if (hitReady) begin
            if (k_q == '0) begin
              hitValid   <= 1'b0;
              hitLast    <= 1'b0;
              hitInfo    <= '0;
              overflow   <= 1'b0;
              ovf_q      <= 1'b0;
              queryReady <= 1'b1;
              state_q    <= IDLE;
            end else begin
              k_q     <= km1_w;
              hitInfo <= row_q[km1_w];
              hitLast <= (km1_w == '0);
            end
          end
        end

        NOHIT: begin
          if (hitReady) begin
            hitValid   <= 1'b0;
            noHit      <= 1'b0;
            hitLast    <= 1'b0;
            queryReady <= 1'b1;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q    <= IDLE;
          queryReady <= 1'b1;
          hitValid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssid_hit_readout.sv
module tb_ssid_hit_readout;

  logic        clock = 1'b0;
  logic        resetN;
  logic        queryValid;
  logic [11:0] querySSID;
  logic        queryReady;
  logic [6:0]  hnmAddr;
  logic [31:0] hnmData;
  logic [11:0] hcmAddr;
  logic [15:0] hcmData;
  logic [8:0]  hlmAddr;
  logic [63:0] hlmData;
  logic        hitValid, hitReady, hitLast, noHit, overflow;
  logic [7:0]  hitInfo;

  int checks = 0;
  int errors = 0;

  ssid_hit_readout dut (
    .clock(clock), .resetN(resetN),
    .queryValid(queryValid), .querySSID(querySSID), .queryReady(queryReady),
    .hnmAddr(hnmAddr), .hnmData(hnmData),
    .hcmAddr(hcmAddr), .hcmData(hcmData),
    .hlmAddr(hlmAddr), .hlmData(hlmData),
    .hitValid(hitValid), .hitReady(hitReady), .hitInfo(hitInfo),
    .hitLast(hitLast), .noHit(noHit), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // storage model: synchronous reads, 1-cycle latency
  logic [31:0] hnm [128];
  logic [15:0] hcm [4096];
  logic [63:0] hlm [512];
  always @(posedge clock) begin
    hnmData <= hnm[hnmAddr];
    hcmData <= hcm[hcmAddr];
    hlmData <= hlm[hlmAddr];
  end

  typedef struct {
    logic [11:0]     ssid;
    logic            nohit;
    int              lat;
    int              nb;
    logic            ovf;
    logic [7:0][7:0] beats;  // element b = b-th emitted word
  } vec_t;

  vec_t tab [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Leaves the bench at the negedge of cycle 0 (accept edge just passed).
  task automatic start_query(input logic [11:0] ssid, input bit hold);
    @(negedge clock);
    querySSID  = ssid;
    queryValid = 1'b1;
    check("query_ready_idle", queryReady, 1'b1);
    @(posedge clock);
    @(negedge clock);
    if (!hold) queryValid = 1'b0;
  endtask

  task automatic wait_first(input int lat, input string name);
    int t = 0;
    while (!hitValid && t < 40) begin
      @(negedge clock);
      t++;
    end
    check(name, t, lat);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [11:0] exp_beat;
    start_query(v.ssid, 1'b0);
    wait_first(v.lat, {name, "_latency"});
    for (int b = 0; b < v.nb; b++) begin
      if (v.nohit) exp_beat = {1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
      else         exp_beat = {1'b1, v.beats[b], (b == v.nb - 1), 1'b0, v.ovf};
      check({name, "_beat"}, {hitValid, hitInfo, hitLast, noHit, overflow}, exp_beat);
      @(negedge clock);
    end
    check({name, "_idle"}, {queryReady, hitValid}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++)  hnm[i] = '0;
    for (int i = 0; i < 4096; i++) hcm[i] = '0;
    for (int i = 0; i < 512; i++)  hlm[i] = '0;
    hcm[12'h0A3] = 16'h0973;  // addr 0x012, junk in middle bits, cnt 3
    hcm[12'h0A4] = 16'h100B;  // addr 0x020, cnt 11
    hcm[12'h0A5] = 16'h0000;  // cnt 0
    hcm[12'h0A6] = 16'h1801;  // addr 0x030, cnt 1
    hcm[12'h0A7] = 16'hFF88;  // addr 0x1FF, cnt 8
    hcm[12'h0A8] = 16'h2009;  // addr 0x040, cnt 9
    hlm[9'h012] = 64'hA5A5A5A5A5332211;
    hlm[9'h020] = 64'h8877665544332211;
    hlm[9'h030] = 64'hFFEEDDCCBBAA99AB;
    hlm[9'h1FF] = 64'h0102030405060708;
    hlm[9'h040] = 64'hF0E0D0C0B0A09080;

    tab[0] = '{12'h0A3, 1'b1, 2, 1, 1'b0, 64'h0};
    tab[1] = '{12'h0A3, 1'b0, 6, 3, 1'b0, 64'h0000000000112233};
    tab[2] = '{12'h0A4, 1'b0, 6, 8, 1'b1, 64'h1122334455667788};
    tab[3] = '{12'h0A5, 1'b1, 4, 1, 1'b0, 64'h0};
    tab[4] = '{12'h0A6, 1'b0, 6, 1, 1'b0, 64'h00000000000000AB};
    tab[5] = '{12'h0A7, 1'b0, 6, 8, 1'b0, 64'h0807060504030201};
    tab[6] = '{12'h0C3, 1'b1, 2, 1, 1'b0, 64'h0};

    resetN = 1'b0; queryValid = 1'b0; querySSID = '0; hitReady = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_state",
          {queryReady, hitValid, hitLast, noHit, overflow, hitInfo, hnmAddr, hcmAddr, hlmAddr},
          {1'b1, 4'b0, 8'h0, 7'h0, 12'h0, 9'h0});
    resetN = 1'b1;

    // HNM bit 3 of row 5 still clear: miss
    run_vec(tab[0], "miss");
    hnm[5] = 32'h000001F8;  // bits 3..8 set
    for (int i = 1; i < 7; i++) run_vec(tab[i], $sformatf("vec%0d", i));
    begin
      vec_t v9 = '{12'h0A8, 1'b0, 6, 8, 1'b1, 64'h8090A0B0C0D0E0F0};
      run_vec(v9, "cnt9_ovf");
    end

    // backpressure: hold the second beat for 4 cycles
    start_query(12'h0A3, 1'b0);
    wait_first(6, "bp_latency");
    check("bp_beat0", {hitValid, hitInfo, hitLast}, {1'b1, 8'h33, 1'b0});
    @(negedge clock);
    check("bp_beat1", {hitValid, hitInfo, hitLast}, {1'b1, 8'h22, 1'b0});
    hitReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("bp_hold", {hitValid, hitInfo, hitLast, noHit, overflow}, {1'b1, 8'h22, 3'b000});
    end
    hitReady = 1'b1;
    @(negedge clock);
    check("bp_beat2", {hitValid, hitInfo, hitLast}, {1'b1, 8'h11, 1'b1});
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_no_extra", {hitValid, queryReady}, 2'b01);
    end

    // busy: queryValid held high, ignored until the stream ends
    begin
      int t = 0, nb = 0, rdy_hi = 0;
      start_query(12'h0A3, 1'b1);
      while (t < 60) begin
        if (queryReady) rdy_hi++;
        if (hitValid) begin
          nb++;
          if (hitLast) break;
        end
        @(negedge clock);
        t++;
      end
      check("busy_beats", nb, 3);
      check("busy_ready_low", rdy_hi, 0);
      querySSID = 12'h0C3;
      @(negedge clock);
      check("busy_ready_back", {queryReady, hitValid}, 2'b10);
      @(negedge clock);
      queryValid = 1'b0;
      check("busy_next_accepted", queryReady, 1'b0);
      wait_first(2, "busy_next_latency");
      check("busy_next_beat", {hitValid, hitInfo, hitLast, noHit}, {1'b1, 8'h00, 2'b11});
      @(negedge clock);
    end

    // reset mid-EMIT
    start_query(12'h0A4, 1'b0);
    wait_first(6, "rst_latency");
    @(negedge clock);
    @(negedge clock);
    check("rst_pre", {hitValid, hitInfo}, {1'b1, 8'h66});
    #1 resetN = 1'b0;
    #1 check("rst_async", {hitValid, queryReady, overflow}, 3'b010);
    @(negedge clock);
    check("rst_held", {hitValid, queryReady}, 2'b01);
    resetN = 1'b1;
    run_vec(tab[1], "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
